// File: rtl/rv32i_mc_ctrl_if.sv
// rv32i multi-cycle control: shared memory port bundle.
// The controller is the master; the memory side is the slave.
interface rv32i_mc_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/rv32i_mc_ctrl.sv
// rv32i multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP
// sequencing over one shared memory port, with bus-timeout trap.
module rv32i_mc_ctrl #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_taken,
  rv32i_mc_ctrl_if.master bus,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  imm_type,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [3:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  localparam logic [6:0] OPC_LUI   = 7'h37;
  localparam logic [6:0] OPC_AUIPC = 7'h17;
  localparam logic [6:0] OPC_JAL   = 7'h6F;
  localparam logic [6:0] OPC_JALR  = 7'h67;
  localparam logic [6:0] OPC_BR    = 7'h63;
  localparam logic [6:0] OPC_LD    = 7'h03;
  localparam logic [6:0] OPC_ST    = 7'h23;
  localparam logic [6:0] OPC_OPI   = 7'h13;
  localparam logic [6:0] OPC_OP    = 7'h33;

  localparam int TW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LIM =
    TW'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);
  localparam logic TMO_EN = (BUS_TIMEOUT != 0);

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q;
  logic [1:0]    cause_q, cause_d;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_br;
  logic       is_ld, is_st, is_opi, is_op, legal;
  logic [2:0] imm_dec;
  logic       req_c, we_c, asel_c, tmo_hit;
  logic       unused;

  assign opc      = instr[6:0];
  assign f3       = instr[14:12];
  assign is_lui   = (opc == OPC_LUI);
  assign is_auipc = (opc == OPC_AUIPC);
  assign is_jal   = (opc == OPC_JAL);
  assign is_jalr  = (opc == OPC_JALR);
  assign is_br    = (opc == OPC_BR);
  assign is_ld    = (opc == OPC_LD);
  assign is_st    = (opc == OPC_ST);
  assign is_opi   = (opc == OPC_OPI);
  assign is_op    = (opc == OPC_OP);
  assign legal    = is_lui | is_auipc | is_jal | is_jalr | is_br
                  | is_ld | is_st | is_opi | is_op;
  assign unused   = ^{instr[31], instr[29:15], instr[11:7]};

  // Immediate format for the opcode held in IR.
  always_comb begin
    imm_dec = 3'd0;
    unique case (1'b1)
      is_st:            imm_dec = 3'd1;
      is_br:            imm_dec = 3'd2;
      is_lui | is_auipc: imm_dec = 3'd3;
      is_jal:           imm_dec = 3'd4;
      default:          imm_dec = 3'd0;
    endcase
  end

  // Timeout fires on the last allowed waiting cycle without mem_ready.
  assign tmo_hit = TMO_EN && req_c && !bus.mem_ready
                && (tmo_q == TMO_LIM);

  // Next state and decoded control outputs; reset forces all to zero.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    req_c      = 1'b0;
    we_c       = 1'b0;
    asel_c     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'd0;
    imm_type   = 3'd0;
    alu_a_sel  = 2'd0;
    alu_b_sel  = 1'b0;
    alu_op     = 4'd0;
    rf_we      = 1'b0;
    wb_sel     = 2'd0;
    retire     = 1'b0;
    trap       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end
      end
      S_DECODE: begin
        imm_type = imm_dec;
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end
      end
      S_EXEC: begin
        imm_type = imm_dec;
        unique case (1'b1)
          is_op: begin
            alu_op  = {instr[30], f3};
            state_d = S_WB;
          end
          is_opi: begin
            alu_b_sel = 1'b1;
            alu_op    = {(f3 == 3'b101) & instr[30], f3};
            state_d   = S_WB;
          end
          is_lui: begin
            alu_a_sel = 2'd2;
            alu_b_sel = 1'b1;
            state_d   = S_WB;
          end
          is_auipc: begin
            alu_a_sel = 2'd1;
            alu_b_sel = 1'b1;
            state_d   = S_WB;
          end
          is_ld | is_st: begin
            alu_b_sel = 1'b1;
            state_d   = S_MEM;
          end
          is_br: begin
            alu_a_sel = 2'd1;
            alu_b_sel = 1'b1;
            pc_we     = 1'b1;
            pc_sel    = br_taken ? 2'd1 : 2'd0;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end
          is_jal | is_jalr: begin
            alu_a_sel = is_jal ? 2'd1 : 2'd0;
            alu_b_sel = 1'b1;
            rf_we     = 1'b1;
            wb_sel    = 2'd2;
            pc_we     = 1'b1;
            pc_sel    = is_jal ? 2'd1 : 2'd2;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end
          default: begin
            state_d = S_TRAP;
            cause_d = 2'd1;
          end
        endcase
      end
      S_MEM: begin
        imm_type  = imm_dec;
        alu_b_sel = 1'b1;
        req_c     = 1'b1;
        asel_c    = 1'b1;
        we_c      = is_st;
        if (bus.mem_ready) begin
          if (is_st) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end
      end
      S_WB: begin
        imm_type = imm_dec;
        rf_we    = 1'b1;
        wb_sel   = is_ld ? 2'd1 : 2'd0;
        pc_we    = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    if (rst) begin
      req_c     = 1'b0;
      we_c      = 1'b0;
      asel_c    = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 2'd0;
      imm_type  = 3'd0;
      alu_a_sel = 2'd0;
      alu_b_sel = 1'b0;
      alu_op    = 4'd0;
      rf_we     = 1'b0;
      wb_sel    = 2'd0;
      retire    = 1'b0;
      trap      = 1'b0;
    end
  end

  assign bus.mem_req      = req_c;
  assign bus.mem_we       = we_c;
  assign bus.mem_addr_sel = asel_c;
  assign trap_cause       = rst ? 2'd0 : cause_q;

  // State, wait counter and sticky trap cause registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      tmo_q   <= '0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if ((state_d != state_q)
          && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
        tmo_q <= '0;
      end else if (TMO_EN && req_c && !bus.mem_ready) begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Directed bench for rv32i_mc_ctrl: instruction sequencing,
// memory waits, traps and reset recovery.
module tb_rv32i_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        br_taken = 1'b0;
  logic        ir_we, pc_we, alu_b_sel, rf_we, retire, trap;
  logic [1:0]  pc_sel, alu_a_sel, wb_sel, trap_cause;
  logic [2:0]  imm_type;
  logic [3:0]  alu_op;

  int checks = 0;
  int errors = 0;
  int n;

  rv32i_mc_ctrl_if bus();

  rv32i_mc_ctrl #(.BUS_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .br_taken   (br_taken),
    .bus        (bus.master),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .imm_type   (imm_type),
    .alu_a_sel  (alu_a_sel),
    .alu_b_sel  (alu_b_sel),
    .alu_op     (alu_op),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .retire     (retire),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_ready = 1'b1;
    instr = 32'h67F00013;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", bus.mem_req, 0);
    chk("rst_irwe", ir_we, 0);
    chk("rst_retire", retire, 0);
    chk("rst_trap", trap, 0);
    chk("rst_cause", trap_cause, 0);

    // ADDI stream, zero-wait memory
    rst = 1'b0;
    #1;
    chk("addi_f_req", bus.mem_req, 1);
    chk("addi_f_irwe", ir_we, 1);
    chk("addi_f_asel", bus.mem_addr_sel, 0);
    cyc();
    chk("addi_d_req", bus.mem_req, 0);
    chk("addi_d_imm", imm_type, 0);
    cyc();
    chk("addi_e_bsel", alu_b_sel, 1);
    chk("addi_e_asel", alu_a_sel, 0);
    chk("addi_e_op", alu_op, 4'b0000);
    cyc();
    chk("addi_w_rfwe", rf_we, 1);
    chk("addi_w_wbsel", wb_sel, 0);
    chk("addi_w_pcwe", pc_we, 1);
    chk("addi_w_retire", retire, 1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      n += int'(retire);
    end
    chk("addi_cpi4", n, 2);

    // LW with 3 wait cycles in MEM
    cyc();
    instr = 32'h0000A083;
    #1;
    chk("lw_f_irwe", ir_we, 1);
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    chk("lw_d_imm", imm_type, 0);
    cyc();
    chk("lw_e_bsel", alu_b_sel, 1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) begin
        bus.mem_ready = 1'b1;
        #1;
      end
      n += int'(bus.mem_req);
      chk("lw_m_we", bus.mem_we, 0);
      chk("lw_m_asel", bus.mem_addr_sel, 1);
      chk("lw_m_retire", retire, 0);
    end
    chk("lw_req_cycles", n, 4);
    cyc();
    chk("lw_w_req", bus.mem_req, 0);
    chk("lw_w_wbsel", wb_sel, 1);
    chk("lw_w_rfwe", rf_we, 1);
    chk("lw_w_retire", retire, 1);

    // SB store
    cyc();
    instr = 32'h660000A3;
    #1;
    chk("sb_f_irwe", ir_we, 1);
    cyc();
    chk("sb_d_imm", imm_type, 1);
    cyc();
    chk("sb_e_bsel", alu_b_sel, 1);
    chk("sb_e_retire", retire, 0);
    cyc();
    chk("sb_m_we", bus.mem_we, 1);
    chk("sb_m_asel", bus.mem_addr_sel, 1);
    chk("sb_m_pcwe", pc_we, 1);
    chk("sb_m_pcsel", pc_sel, 0);
    chk("sb_m_retire", retire, 1);
    chk("sb_m_rfwe", rf_we, 0);

    // BEQ taken then not taken
    cyc();
    instr = 32'h6C0008E3;
    br_taken = 1'b1;
    #1;
    chk("beq_f_req", bus.mem_req, 1);
    cyc();
    chk("beq_d_imm", imm_type, 2);
    cyc();
    chk("beq_t_pcwe", pc_we, 1);
    chk("beq_t_pcsel", pc_sel, 1);
    chk("beq_t_asel", alu_a_sel, 1);
    chk("beq_t_retire", retire, 1);
    cyc();
    cyc();
    br_taken = 1'b0;
    cyc();
    chk("beq_n_pcsel", pc_sel, 0);
    chk("beq_n_pcwe", pc_we, 1);

    // JAL, JALR, LUI
    cyc();
    instr = 32'h7797F06F;
    #1;
    cyc();
    chk("jal_d_imm", imm_type, 4);
    cyc();
    chk("jal_e_rfwe", rf_we, 1);
    chk("jal_e_wbsel", wb_sel, 2);
    chk("jal_e_pcsel", pc_sel, 1);
    chk("jal_e_asel", alu_a_sel, 1);
    chk("jal_e_retire", retire, 1);
    cyc();
    instr = 32'h000100E7;
    #1;
    chk("jal_next_fetch", ir_we, 1);
    cyc();
    chk("jalr_d_imm", imm_type, 0);
    cyc();
    chk("jalr_e_pcsel", pc_sel, 2);
    chk("jalr_e_asel", alu_a_sel, 0);
    chk("jalr_e_rfwe", rf_we, 1);
    cyc();
    instr = 32'h8FFFA037;
    #1;
    cyc();
    chk("lui_d_imm", imm_type, 3);
    cyc();
    chk("lui_e_asel", alu_a_sel, 2);
    chk("lui_e_bsel", alu_b_sel, 1);
    chk("lui_e_op", alu_op, 0);
    cyc();
    chk("lui_w_rfwe", rf_we, 1);

    // SUB (OP) and SRAI (OPI) alu_op encoding
    cyc();
    instr = 32'h40208033;
    #1;
    cyc();
    cyc();
    chk("sub_e_op", alu_op, 4'b1000);
    chk("sub_e_bsel", alu_b_sel, 0);
    cyc();
    cyc();
    instr = 32'h4010D093;
    #1;
    cyc();
    cyc();
    chk("srai_e_op", alu_op, 4'b1101);
    cyc();

    // Illegal opcode
    cyc();
    instr = 32'h0000007F;
    #1;
    cyc();
    chk("ill_d_trap", trap, 0);
    cyc();
    chk("ill_trap", trap, 1);
    chk("ill_cause", trap_cause, 1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n += int'(bus.mem_req);
    end
    chk("ill_req_quiet", n, 0);
    chk("ill_hold_cause", trap_cause, 1);

    // Bus timeout in FETCH
    rst = 1'b1;
    cyc();
    chk("rst2_trap", trap, 0);
    chk("rst2_cause", trap_cause, 0);
    instr = 32'h67F00013;
    bus.mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) cyc();
      n += int'(bus.mem_req);
    end
    chk("tmo_req_cycles", n, 16);
    cyc();
    chk("tmo_trap", trap, 1);
    chk("tmo_cause", trap_cause, 2);
    chk("tmo_req_drop", bus.mem_req, 0);

    // mem_ready on the 16th waiting cycle completes normally
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) cyc();
    bus.mem_ready = 1'b1;
    #1;
    chk("lim_irwe", ir_we, 1);
    cyc();
    chk("lim_no_trap", trap, 0);
    chk("lim_imm", imm_type, 0);

    // Reset in the middle of a waiting fetch
    cyc();
    cyc();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("mid_req", bus.mem_req, 1);
    rst = 1'b1;
    cyc();
    chk("mid_rst_req", bus.mem_req, 0);
    chk("mid_rst_irwe", ir_we, 0);
    rst = 1'b0;
    #1;
    chk("mid_restart_req", bus.mem_req, 1);
    for (int i = 0; i < 14; i++) cyc();
    chk("mid_15_no_trap", trap, 0);
    cyc();
    bus.mem_ready = 1'b1;
    #1;
    chk("mid_16_irwe", ir_we, 1);
    chk("mid_16_no_trap", trap, 0);
    cyc();
    chk("mid_decode_cause", trap_cause, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
